// File: rtl/mips_wb_pkg.sv
// ============================================================================
// Package : mips_wb_pkg
// Shared encodings for the MIPS MEM/WB writeback stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_wb_pkg;

  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] RESULT_LINK = 2'b10;

  localparam logic [1:0] LOAD_WORD = 2'b00;
  localparam logic [1:0] LOAD_HALF = 2'b01;
  localparam logic [1:0] LOAD_BYTE = 2'b10;

  typedef enum logic {
    WB_RUN  = 1'b0,
    WB_TRAP = 1'b1
  } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_load_align.sv
// ============================================================================
// Module  : wb_load_align
// Little-endian load lane selection, sign/zero extension and misalign detect.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_load_align
  import mips_wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] iMemData,
  input  logic [1:0]        iAddr,
  input  logic [1:0]        iLoadSize,
  input  logic              iLoadUnsigned,
  output logic [DATA_W-1:0] oData,
  output logic              oMisalign
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (iAddr)
      2'd0:    byte_lane = iMemData[7:0];
      2'd1:    byte_lane = iMemData[15:8];
      2'd2:    byte_lane = iMemData[23:16];
      default: byte_lane = iMemData[31:24];
    endcase
    half_lane = iAddr[1] ? iMemData[31:16] : iMemData[15:0];

    oData     = iMemData;
    oMisalign = 1'b0;
    case (iLoadSize)
      LOAD_BYTE: oData = {{(DATA_W-8){byte_lane[7] & ~iLoadUnsigned}}, byte_lane};
      LOAD_HALF: begin
        oData     = {{(DATA_W-16){half_lane[15] & ~iLoadUnsigned}}, half_lane};
        oMisalign = iAddr[0];
      end
      LOAD_WORD: oMisalign = |iAddr;
      // reserved size behaves as a word load
      default:   oMisalign = |iAddr;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module  : mem_wb_stage
// MEM/WB pipeline register with writeback selection and misaligned-load trap.
// Optional retired-instruction counter enabled by macro WB_RETIRE_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage
  import mips_wb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int LINK_OFFSET = 4
) (
  input  logic              iCLK,
  input  logic              iCLR_n,
  input  logic              iStall,
  input  logic              iFlush,
  input  logic              iValid,
  input  logic              iRegWrite,
  input  logic [REG_AW-1:0] iWriteRegister,
  input  logic [1:0]        iResultSel,
  input  logic [DATA_W-1:0] iALUResult,
  input  logic [DATA_W-1:0] iMemData,
  input  logic [1:0]        iLoadSize,
  input  logic              iLoadUnsigned,
  input  logic [DATA_W-1:0] iPC,
  input  logic              iExcAck,
  output logic              oValid,
  output logic              oRegWrite,
  output logic [REG_AW-1:0] oWriteRegister,
  output logic [DATA_W-1:0] oWriteData,
  output logic              oMisalign,
  output logic [DATA_W-1:0] oExcAddr,
  output logic [DATA_W-1:0] oExcPC,
  output logic [31:0]       oRetired
);

  wb_state_t         state_q, state_d;
  logic              valid_q, valid_d;
  logic              reg_write_q, reg_write_d;
  logic [REG_AW-1:0] write_register_q, write_register_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              misalign_q, misalign_d;
  logic [DATA_W-1:0] exc_addr_q, exc_addr_d;
  logic [DATA_W-1:0] exc_pc_q, exc_pc_d;

  logic [DATA_W-1:0] load_data;
  logic              align_fault;
  logic              load_misalign;
  logic              capture;
  logic [DATA_W-1:0] result;

  wb_load_align #(.DATA_W(DATA_W)) u_align (
    .iMemData      (iMemData),
    .iAddr         (iALUResult[1:0]),
    .iLoadSize     (iLoadSize),
    .iLoadUnsigned (iLoadUnsigned),
    .oData         (load_data),
    .oMisalign     (align_fault)
  );

  assign capture       = ~iFlush & ~iStall;
  assign load_misalign = iValid & (iResultSel == RESULT_LOAD) & align_fault;

  always_comb begin
    case (iResultSel)
      RESULT_ALU:  result = iALUResult;
      RESULT_LOAD: result = load_data;
      RESULT_LINK: result = iPC + DATA_W'(LINK_OFFSET);
      default:     result = iALUResult;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    valid_d          = valid_q;
    reg_write_d      = reg_write_q;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    misalign_d       = misalign_q;
    exc_addr_d       = exc_addr_q;
    exc_pc_d         = exc_pc_q;

    if (iFlush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (!iStall) begin
      write_register_d = iWriteRegister;
      write_data_d     = result;
      if (state_q == WB_RUN) begin
        valid_d     = iValid;
        reg_write_d = iValid & iRegWrite & (iWriteRegister != '0) & ~load_misalign;
        if (load_misalign) begin
          misalign_d = 1'b1;
          exc_addr_d = iALUResult;
          exc_pc_d   = iPC;
          state_d    = WB_TRAP;
        end
      end else begin
        // younger instructions are squashed while the trap is pending
        valid_d     = 1'b0;
        reg_write_d = 1'b0;
      end
    end

    // acknowledge is honoured on any edge that is not a pure stall
    if ((state_q == WB_TRAP) && iExcAck && (iFlush || !iStall)) begin
      state_d    = WB_RUN;
      misalign_d = 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iCLR_n) begin
    if (!iCLR_n) begin
      state_q          <= WB_RUN;
      valid_q          <= 1'b0;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
      misalign_q       <= 1'b0;
      exc_addr_q       <= '0;
      exc_pc_q         <= '0;
    end else begin
      state_q          <= state_d;
      valid_q          <= valid_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      misalign_q       <= misalign_d;
      exc_addr_q       <= exc_addr_d;
      exc_pc_q         <= exc_pc_d;
    end
  end

  assign oValid         = valid_q;
  assign oRegWrite      = reg_write_q;
  assign oWriteRegister = write_register_q;
  assign oWriteData     = write_data_q;
  assign oMisalign      = misalign_q;
  assign oExcAddr       = exc_addr_q;
  assign oExcPC         = exc_pc_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (capture && (state_q == WB_RUN) && iValid && !load_misalign) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge iCLK or negedge iCLR_n) begin
    if (!iCLR_n) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign oRetired = retired_q;
`else
  assign oRetired = '0;
`endif

endmodule

`default_nettype wire
